// File: rtl/fifo_stream.sv
// rtl/fifo_stream.sv - Parametrised word FIFO replaying stored words as spaced output strobes
// Optional build macro FIFO_STREAM_DROP_OLDEST_EN: a write into a full FIFO with no read overwrites the oldest word.
module fifo_stream #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int GAP       = 0,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_d_rdy,
    input  logic             rdy2rcv,
    output logic [WIDTH-1:0] out_data,
    output logic             out_d_rdy,
    output logic [AW:0]      level,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow
);

    // Gap counter needs at least one bit even when no spacing is requested.
    localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [AW:0]   DEPTH_L  = DEPTH[AW:0];
    localparam logic [AW:0]   AF_L     = AF_THRESH[AW:0];
    localparam logic [GW-1:0] GAP_L    = GAP[GW-1:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [GW-1:0] GAP_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [GW-1:0]    gap_cnt;

    logic rd_fire;
    logic wr_ok;
    logic wr_full_hit;
    logic drop_oldest;
    logic mem_we;

    assign level       = cnt;
    assign empty       = (cnt == '0);
    assign full        = (cnt == DEPTH_L);
    assign almost_full = (cnt >= AF_L);

    // A word leaves only when the consumer is ready and the spacing interval has elapsed.
    assign rd_fire     = rdy2rcv & ~empty & (gap_cnt == '0);
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_ok       = in_d_rdy & (~full | rd_fire);
    assign wr_full_hit = in_d_rdy & full & ~rd_fire;

`ifdef FIFO_STREAM_DROP_OLDEST_EN
    assign drop_oldest = wr_full_hit;
`else
    assign drop_oldest = 1'b0;
`endif

    assign mem_we = wr_ok | drop_oldest;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, output strobe, spacing counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            out_data  <= '0;
            out_d_rdy <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (rd_fire) begin
                out_data  <= mem[rd_ptr];
                out_d_rdy <= 1'b1;
                gap_cnt   <= GAP_L;
            end else begin
                out_d_rdy <= 1'b0;
                if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GAP_ONE;
                end
            end

            // Overwriting the oldest word advances the read side past it as well.
            if (rd_fire || drop_oldest) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_ok || drop_oldest) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (wr_ok && !rd_fire) begin
                cnt <= cnt + CNT_ONE;
            end else if (rd_fire && !wr_ok) begin
                cnt <= cnt - CNT_ONE;
            end

            if (wr_full_hit) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
